// File: rtl/vdp_pkg.sv
// Shared constants, types and encodings for the VDP CPU-port controller.
package vdp_pkg;

    localparam int VRAM_AW  = 14;
    localparam int NUM_REGS = 8;

    // port_sel encodings
    localparam logic PORT_DATA = 1'b0;   // 0xBE
    localparam logic PORT_CTRL = 1'b1;   // 0xBF

    // Status byte bit positions
    localparam int STAT_F  = 7;
    localparam int STAT_5S = 6;
    localparam int STAT_C  = 5;

    // Sprite number reported while no fifth-sprite event is latched
    localparam logic [4:0] FIFTH_NONE = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_ACK = 2'd2
    } vram_state_e;

    // One VRAM access as issued to the memory side
    typedef struct packed {
        logic               we;
        logic [VRAM_AW-1:0] addr;
        logic [7:0]         wdata;
    } vram_acc_t;

endpackage

// File: rtl/vdp_status.sv
// VDP status flags (frame, fifth sprite, collision), fifth-sprite number
// capture and the registered interrupt output.
module vdp_status
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vsync_set,
    input  logic       coll_set,
    input  logic       fifth_set,
    input  logic [4:0] fifth_num,
    input  logic       clr,
    input  logic       irq_en,
    output logic [7:0] status,
    output logic       int_n
);

    logic       f_q, f_d;
    logic       s5_q, s5_d;
    logic       c_q, c_d;
    logic [4:0] num_q, num_d;
    logic       int_n_q, int_n_d;

    // Next-state: a set in the clear cycle wins so no event is lost
    always_comb begin
        f_d     = vsync_set | (f_q  & ~clr);
        s5_d    = fifth_set | (s5_q & ~clr);
        c_d     = coll_set  | (c_q  & ~clr);
        num_d   = num_q;
        if (!s5_q && fifth_set) begin
            num_d = fifth_num;
        end
        int_n_d = ~(f_d & irq_en);
    end

    // Flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_q     <= 1'b0;
            s5_q    <= 1'b0;
            c_q     <= 1'b0;
            num_q   <= FIFTH_NONE;
            int_n_q <= 1'b1;
        end else begin
            f_q     <= f_d;
            s5_q    <= s5_d;
            c_q     <= c_d;
            num_q   <= num_d;
            int_n_q <= int_n_d;
        end
    end

    // Assemble the status byte; number field only meaningful once 5S is set
    always_comb begin
        status          = '0;
        status[STAT_F]  = f_q;
        status[STAT_5S] = s5_q;
        status[STAT_C]  = c_q;
        status[4:0]     = s5_q ? num_q : FIFTH_NONE;
    end

    assign int_n = int_n_q;

endmodule

// File: rtl/vdp_ctrl.sv
// VDP CPU-port controller: control/data port decode, register file,
// VRAM address/read-buffer handling and a single-outstanding VRAM
// access engine with one pending slot.
module vdp_ctrl
    import vdp_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               io_wr,
    input  logic               io_rd,
    input  logic               port_sel,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic [63:0]        regs,
    input  logic               vsync_set,
    input  logic               coll_set,
    input  logic               fifth_set,
    input  logic [4:0]         fifth_num,
    output logic [7:0]         status,
    output logic               int_n,
    output logic               overrun
);

    vram_state_e state_q, state_d;

    logic [VRAM_AW-1:0]         addr_q, addr_d;
    logic [7:0]                 latch_q, latch_d;
    logic                       flag_q, flag_d;
    logic [7:0]                 rbuf_q, rbuf_d;
    logic [7:0]                 dout_q, dout_d;
    logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
    logic                       stat_clr_q, stat_clr_d;
    vram_acc_t                  cur_q, cur_d;
    vram_acc_t                  slot_q, slot_d;
    logic                       slot_v_q, slot_v_d;
    logic                       overrun_q, overrun_d;

    logic       wr, rd, data_wr, ctrl_wr, data_rd, stat_rd;
    logic       busy, ack_fire;
    logic       acc_v;
    vram_acc_t  acc;
    logic [VRAM_AW-1:0] new_addr;

    // A write strobe takes precedence over a simultaneous read strobe
    assign wr      = io_wr;
    assign rd      = io_rd & ~io_wr;
    assign data_wr = wr & (port_sel == PORT_DATA);
    assign ctrl_wr = wr & (port_sel == PORT_CTRL);
    assign data_rd = rd & (port_sel == PORT_DATA);
    assign stat_rd = rd & (port_sel == PORT_CTRL);

    assign busy     = (state_q != ST_IDLE);
    assign ack_fire = busy & vram_ack;
    assign new_addr = {din[5:0], latch_q};

    // CPU port decode: register/address updates and new VRAM access request.
    // Every prefetch read consumes the address it reads, so the address
    // points past it afterwards (read setup included).
    always_comb begin
        addr_d     = addr_q;
        latch_d    = latch_q;
        flag_d     = flag_q;
        rbuf_d     = rbuf_q;
        dout_d     = dout_q;
        regs_d     = regs_q;
        stat_clr_d = stat_rd;
        acc_v      = 1'b0;
        acc        = '0;

        if (ack_fire && !cur_q.we) begin
            rbuf_d = vram_rdata;
        end

        if (ctrl_wr) begin
            if (!flag_q) begin
                latch_d = din;
                flag_d  = 1'b1;
            end else begin
                flag_d = 1'b0;
                if (din[7]) begin
                    if (din[5:3] == 3'b000) begin
                        regs_d[din[2:0]] = latch_q;
                    end
                end else if (din[6]) begin
                    addr_d = new_addr;
                end else begin
                    acc_v      = 1'b1;
                    acc.we     = 1'b0;
                    acc.addr   = new_addr;
                    addr_d     = new_addr + 1'b1;
                end
            end
        end else if (data_wr) begin
            acc_v     = 1'b1;
            acc.we    = 1'b1;
            acc.addr  = addr_q;
            acc.wdata = din;
            addr_d    = addr_q + 1'b1;
            rbuf_d    = din;
            flag_d    = 1'b0;
        end else if (data_rd) begin
            dout_d   = rbuf_q;
            acc_v    = 1'b1;
            acc.we   = 1'b0;
            acc.addr = addr_q;
            addr_d   = addr_q + 1'b1;
            flag_d   = 1'b0;
        end else if (stat_rd) begin
            dout_d = status;
            flag_d = 1'b0;
        end
    end

    // Access routing: start from the slot first, queue while busy, drop on overflow
    always_comb begin
        cur_d     = cur_q;
        slot_d    = slot_q;
        slot_v_d  = slot_v_q;
        overrun_d = overrun_q;
        if (!busy) begin
            if (slot_v_q) begin
                cur_d = slot_q;
                if (acc_v) begin
                    slot_d = acc;
                end else begin
                    slot_v_d = 1'b0;
                end
            end else if (acc_v) begin
                cur_d = acc;
            end
        end else if (acc_v) begin
            if (!slot_v_q) begin
                slot_d   = acc;
                slot_v_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            latch_q    <= '0;
            flag_q     <= 1'b0;
            rbuf_q     <= '0;
            dout_q     <= '0;
            regs_q     <= '0;
            stat_clr_q <= 1'b0;
            cur_q      <= '0;
            slot_q     <= '0;
            slot_v_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            latch_q    <= latch_d;
            flag_q     <= flag_d;
            rbuf_q     <= rbuf_d;
            dout_q     <= dout_d;
            regs_q     <= regs_d;
            stat_clr_q <= stat_clr_d;
            cur_q      <= cur_d;
            slot_q     <= slot_d;
            slot_v_q   <= slot_v_d;
            overrun_q  <= overrun_d;
        end
    end

    // VRAM FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // VRAM FSM next state; an ack seen in IDLE is stale and ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (slot_v_q || acc_v) state_d = ST_REQ;
            ST_REQ:      state_d = vram_ack ? ST_IDLE : ST_WAIT_ACK;
            ST_WAIT_ACK: if (vram_ack) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // VRAM FSM outputs; access fields come from cur_q, held until ack
    always_comb begin
        vram_req   = busy;
        vram_we    = busy & cur_q.we;
        vram_addr  = cur_q.addr;
        vram_wdata = cur_q.wdata;
    end

    vdp_status u_status (
        .clk       (clk),
        .reset_n   (reset_n),
        .vsync_set (vsync_set),
        .coll_set  (coll_set),
        .fifth_set (fifth_set),
        .fifth_num (fifth_num),
        .clr       (stat_clr_q),
        .irq_en    (regs_q[1][5]),
        .status    (status),
        .int_n     (int_n)
    );

    assign dout    = dout_q;
    assign regs    = regs_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_vdp_ctrl.sv
// Directed self-checking bench for vdp_ctrl.
module tb_vdp_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic        port_sel = 1'b0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        vram_req;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = '0;
    logic [63:0] regs;
    logic        vsync_set = 1'b0;
    logic        coll_set = 1'b0;
    logic        fifth_set = 1'b0;
    logic [4:0]  fifth_num = '0;
    logic [7:0]  status;
    logic        int_n;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    vdp_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .io_wr      (io_wr),
        .io_rd      (io_rd),
        .port_sel   (port_sel),
        .din        (din),
        .dout       (dout),
        .vram_req   (vram_req),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_ack   (vram_ack),
        .vram_rdata (vram_rdata),
        .regs       (regs),
        .vsync_set  (vsync_set),
        .coll_set   (coll_set),
        .fifth_set  (fifth_set),
        .fifth_num  (fifth_num),
        .status     (status),
        .int_n      (int_n),
        .overrun    (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic sel, input logic [7:0] d);
        io_wr = 1'b1; port_sel = sel; din = d;
        tick();
        io_wr = 1'b0;
    endtask

    task automatic cpu_rd(input logic sel);
        io_rd = 1'b1; port_sel = sel;
        tick();
        io_rd = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        vram_ack = 1'b1; vram_rdata = d;
        tick();
        vram_ack = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_vram_req", vram_req, 1'b0);
        reset_n = 1'b1;
        tick();
        check("rst_regs", regs, 64'h0);
        check("rst_dout", dout, 8'h00);
        check("rst_vram_req_rel", vram_req, 1'b0);
        check("rst_int_n", int_n, 1'b1);
        check("rst_overrun", overrun, 1'b0);
        check("rst_status", status, 8'h1F);

        // register writes
        cpu_wr(1, 8'h00); cpu_wr(1, 8'h81);
        check("r1_zero", regs, 64'h0);
        cpu_wr(1, 8'hE2); cpu_wr(1, 8'h81);
        check("r1_e2", regs[15:8], 8'hE2);
        check("regs_e2", regs, 64'h0000_0000_0000_E200);
        cpu_wr(1, 8'h55); cpu_wr(1, 8'h8F);
        check("reg_ignored", regs, 64'h0000_0000_0000_E200);
        check("no_vram_from_regs", vram_req, 1'b0);
        check("int_n_no_f", int_n, 1'b1);

        // write setup at 0x0000, two data writes
        cpu_wr(1, 8'h00); cpu_wr(1, 8'h40);
        check("wsetup_no_req", vram_req, 1'b0);
        cpu_wr(0, 8'h11);
        check("w0_req", vram_req, 1'b1);
        check("w0_we", vram_we, 1'b1);
        check("w0_addr", vram_addr, 14'h0000);
        check("w0_data", vram_wdata, 8'h11);
        ack(8'h00);
        check("w0_req_drop", vram_req, 1'b0);
        cpu_wr(0, 8'h22);
        check("w1_addr", vram_addr, 14'h0001);
        check("w1_data", vram_wdata, 8'h22);
        ack(8'h00);
        cpu_rd(0);
        check("rd_after_wr_dout", dout, 8'h22);
        check("rd_after_wr_we", vram_we, 1'b0);
        check("rd_after_wr_addr", vram_addr, 14'h0002);
        ack(8'h5A);

        // read setup at 0x1234
        cpu_wr(1, 8'h34); cpu_wr(1, 8'h12);
        check("rsetup_req", vram_req, 1'b1);
        check("rsetup_we", vram_we, 1'b0);
        check("rsetup_addr", vram_addr, 14'h1234);
        ack(8'hAB);
        cpu_rd(0);
        check("rd_dout_ab", dout, 8'hAB);
        check("rd_prefetch_addr", vram_addr, 14'h1235);
        check("rd_prefetch_req", vram_req, 1'b1);
        ack(8'hCD);
        cpu_rd(0);
        check("rd_dout_cd", dout, 8'hCD);
        ack(8'h00);

        // address wrap
        cpu_wr(1, 8'hFF); cpu_wr(1, 8'h7F);
        cpu_wr(0, 8'h77);
        check("wrap_w_addr", vram_addr, 14'h3FFF);
        ack(8'h00);
        cpu_wr(0, 8'h88);
        check("wrap_next_addr", vram_addr, 14'h0000);
        check("wrap_next_data", vram_wdata, 8'h88);
        ack(8'h00);

        // frame flag and interrupt (R1 bit5 set by 0xE2)
        vsync_set = 1'b1; tick(); vsync_set = 1'b0;
        check("vs_int_n", int_n, 1'b0);
        check("vs_status", status, 8'h9F);
        cpu_rd(1);
        check("st_rd_dout", dout, 8'h9F);
        tick();
        check("st_clr_status", status, 8'h1F);
        check("st_clr_int_n", int_n, 1'b1);
        vsync_set = 1'b1; tick(); vsync_set = 1'b0;
        cpu_rd(1);
        vsync_set = 1'b1; tick(); vsync_set = 1'b0;
        check("set_wins_f", status[7], 1'b1);
        check("set_wins_int_n", int_n, 1'b0);
        cpu_rd(1);
        tick();
        check("f_cleared", status, 8'h1F);

        // fifth sprite and collision
        fifth_num = 5'h0A; fifth_set = 1'b1; coll_set = 1'b1;
        tick();
        fifth_set = 1'b0; coll_set = 1'b0;
        check("fifth_coll", status, 8'h6A);
        fifth_num = 5'h03; fifth_set = 1'b1; tick(); fifth_set = 1'b0;
        check("fifth_hold", status, 8'h6A);
        cpu_rd(1);
        check("fifth_rd_dout", dout, 8'h6A);
        tick();
        check("fifth_clr", status, 8'h1F);

        // simultaneous strobes act as a write (addr now 0x0001)
        io_wr = 1'b1; io_rd = 1'b1; port_sel = 1'b0; din = 8'h3C;
        tick();
        io_wr = 1'b0; io_rd = 1'b0;
        check("both_we", vram_we, 1'b1);
        check("both_addr", vram_addr, 14'h0001);
        check("both_data", vram_wdata, 8'h3C);
        check("both_dout", dout, 8'h6A);
        ack(8'h00);

        // queueing and overrun with ack held low
        cpu_wr(0, 8'hA1);
        cpu_wr(0, 8'hA2);
        cpu_wr(0, 8'hA3);
        check("ovr_set", overrun, 1'b1);
        check("ovr_hold_addr", vram_addr, 14'h0002);
        check("ovr_hold_data", vram_wdata, 8'hA1);
        check("ovr_hold_req", vram_req, 1'b1);
        ack(8'h00);
        check("q_req_drop", vram_req, 1'b0);
        tick();
        check("q_issue_req", vram_req, 1'b1);
        check("q_issue_addr", vram_addr, 14'h0003);
        check("q_issue_data", vram_wdata, 8'hA2);
        tick();
        check("ovr_sticky", overrun, 1'b1);

        // reset mid-request, then a late ack
        reset_n = 1'b0;
        #1;
        check("rst_mid_req", vram_req, 1'b0);
        check("rst_mid_ovr", overrun, 1'b0);
        check("rst_mid_int_n", int_n, 1'b1);
        tick();
        reset_n = 1'b1;
        ack(8'hEE);
        check("late_ack_req", vram_req, 1'b0);
        cpu_rd(0);
        check("late_ack_dout", dout, 8'h00);
        check("late_ack_addr", vram_addr, 14'h0000);
        ack(8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
